// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_RTEXE  = 4'd7,
    ST_RTWB   = 4'd8,
    ST_BEQ    = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JMP    = 4'd12,
    ST_JAL    = 4'd13,
    ST_JR     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that hold a memory request open and are guarded by the watchdog.
  function automatic logic is_mem_wait(state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory-port handshake between the control sequencer and shared memory.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_read, output mem_write,
                  output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_read, input mem_write,
                  input i_or_d, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Watchdog for memory states: counts not-ready cycles, flags a timeout.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout,
  output logic busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] count_q;

  // Wait counter: clear has priority so a state exit always restarts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign timeout = enable && (count_q == LIMIT);
  assign busy    = (count_q != '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic                    zero,
  mc_control_fsm_if.master        bus,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic [1:0]              pc_source,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_op,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic                    reg_write,
  output logic                    instr_done,
  output logic                    fault,
  output logic [3:0]              state_dbg
);

  state_t state_q, state_d;
  logic   fault_q;
  logic   set_fault;
  logic   wait_en;
  logic   wait_clear;
  logic   tmo;
  logic   tmr_busy;

  // Branch resolution happens in the datapath; busy is diagnostic only.
  logic unused_inputs;
  assign unused_inputs = zero ^ tmr_busy;

  // Counter runs only while a memory state is stalled; any exit (ready or
  // timeout) clears it, which also covers the FETCH->FETCH re-entry.
  assign wait_en    = is_mem_wait(state_q) && !bus.mem_ready;
  assign wait_clear = !wait_en || tmo;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_en),
    .timeout (tmo),
    .busy    (tmr_busy)
  );

  // State and sticky fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_fault) fault_q <= 1'b1;
    end
  end

  assign fault     = fault_q;
  assign state_dbg = state_q;

  // Next-state and control-point decode.
  always_comb begin
    state_d       = state_q;
    set_fault     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    instr_done    = 1'b0;

    unique case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        bus.mem_req  = !tmo;
        bus.mem_read = !tmo;
        alu_src_b    = SRCB_FOUR;
        ir_write     = bus.mem_ready;
        pc_write     = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmo) begin
          set_fault = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        unique case (opcode)
          OP_RTYPE:     state_d = (funct == FN_JR) ? ST_JR : ST_RTEXE;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BEQ;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JMP;
          OP_JAL:       state_d = ST_JAL;
          default: begin
            set_fault  = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end

      ST_RTEXE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ST_RTWB;
      end

      ST_RTWB: begin
        reg_dst    = RD_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end

      ST_MEMRD: begin
        bus.mem_req  = !tmo;
        bus.mem_read = !tmo;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEMWB;
        end else if (tmo) begin
          set_fault = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_MEMWB: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEMWR: begin
        bus.mem_req   = !tmo;
        bus.mem_write = !tmo;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (tmo) begin
          set_fault = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        instr_done    = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JMP: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JR: begin
        pc_write   = 1'b1;
        pc_source  = PCS_RS;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors.
module tb_mc_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       req, rd, wr, iord, irw, pcw, pcwc;
    logic [1:0] pcs;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aop;
    logic [1:0] rdst, m2r;
    logic       rw, done, flt;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_write, pc_write, pc_write_cond, alu_src_a, reg_write;
  logic       instr_done, fault;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  mc_control_fsm_if mif();

  mc_control_fsm #(.WAIT_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .bus(mif), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  obs_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_fault = 1'b0;

  // Expected control word for one cycle, straight from the state table.
  function automatic obs_t expect_of(logic [3:0] st, logic rdy, logic to,
                                     logic ill, logic flt);
    obs_t e = '0;
    e.st  = st;
    e.flt = flt;
    case (st)
      ST_FETCH:  begin e.req = !to; e.rd = !to; e.irw = rdy; e.pcw = rdy; e.srcb = 2'b01; end
      ST_DECODE: begin e.srcb = 2'b11; e.done = ill; end
      ST_RTEXE:  begin e.srca = 1'b1; e.aop = 3'b010; end
      ST_RTWB:   begin e.rdst = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      ST_MEMADR: begin e.srca = 1'b1; e.srcb = 2'b10; end
      ST_MEMRD:  begin e.req = !to; e.rd = !to; e.iord = 1'b1; end
      ST_MEMWB:  begin e.m2r = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      ST_MEMWR:  begin e.req = !to; e.wr = !to; e.iord = 1'b1; e.done = rdy; end
      ST_BEQ:    begin e.srca = 1'b1; e.aop = 3'b001; e.pcwc = 1'b1; e.pcs = 2'b01; e.done = 1'b1; end
      ST_ADDIEX: begin e.srca = 1'b1; e.srcb = 2'b10; end
      ST_ADDIWB: begin e.rw = 1'b1; e.done = 1'b1; end
      ST_JMP:    begin e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1; end
      ST_JAL:    begin e.pcw = 1'b1; e.pcs = 2'b10; e.rdst = 2'b10; e.m2r = 2'b10; e.rw = 1'b1; e.done = 1'b1; end
      ST_JR:     begin e.pcw = 1'b1; e.pcs = 2'b11; e.done = 1'b1; end
      default:   ;
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show in it.
  task automatic step(input logic [3:0] st, input logic rdy, input logic to = 1'b0,
                      input logic ill = 1'b0, input logic rst = 1'b0);
    reset         = rst;
    mif.mem_ready = rdy;
    sbq.push_back(expect_of(st, rdy, to, ill, exp_fault));
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  // Monitor: compare every observed cycle that has an expectation queued.
  initial begin
    obs_t got, exp_v;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_v = sbq.pop_front();
        got = '{st: state_dbg, req: mif.mem_req, rd: mif.mem_read, wr: mif.mem_write,
                iord: mif.i_or_d, irw: ir_write, pcw: pc_write, pcwc: pc_write_cond,
                pcs: pc_source, srca: alu_src_a, srcb: alu_src_b, aop: alu_op,
                rdst: reg_dst, m2r: mem_to_reg, rw: reg_write, done: instr_done,
                flt: fault};
        n_vec++;
        if (got !== exp_v) begin
          n_err++;
          $display("FAIL vec%0d ctl: got st=%0d word=%h, expected st=%0d word=%h",
                   n_vec, got.st, got, exp_v.st, exp_v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; mif.mem_ready = 1'b0; zero = 1'b0;
    set_ir(6'b000000, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    step(ST_RST, 1'b0);

    // add
    set_ir(6'b000000, 6'b100000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_RTEXE, 0); step(ST_RTWB, 0);
    // lw with 3 wait cycles
    set_ir(6'b100011, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_MEMADR, 0);
    repeat (3) step(ST_MEMRD, 0);
    step(ST_MEMRD, 1); step(ST_MEMWB, 0);
    // sw with 1 wait cycle
    set_ir(6'b101011, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_MEMADR, 0);
    step(ST_MEMWR, 0); step(ST_MEMWR, 1);
    // beq
    set_ir(6'b000100, 6'b000000); zero = 1'b1;
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_BEQ, 0);
    zero = 1'b0;
    // addi
    set_ir(6'b001000, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_ADDIEX, 0); step(ST_ADDIWB, 0);
    // j
    set_ir(6'b000010, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_JMP, 0);
    // jal
    set_ir(6'b000011, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_JAL, 0);
    // jr
    set_ir(6'b000000, 6'b001000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_JR, 0);
    // illegal opcode: done pulse in DECODE, fault afterwards
    set_ir(6'b111111, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0, 0, 1);
    exp_fault = 1'b1;
    // FSM keeps running with fault held
    set_ir(6'b000000, 6'b100000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_RTEXE, 0); step(ST_RTWB, 0);
    // reset mid-sw abandons it and clears fault
    set_ir(6'b101011, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_MEMADR, 0, 0, 0, 1);
    exp_fault = 1'b0;
    step(ST_RST, 0);
    // lw: ready arrives exactly when the count is at WAIT_MAX -> success
    set_ir(6'b100011, 6'b000000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_MEMADR, 0);
    repeat (15) step(ST_MEMRD, 0);
    step(ST_MEMRD, 1); step(ST_MEMWB, 0);
    // FETCH stuck: 15 waits, then the timeout cycle
    repeat (15) step(ST_FETCH, 0);
    step(ST_FETCH, 0, 1);
    exp_fault = 1'b1;
    set_ir(6'b000000, 6'b100000);
    step(ST_FETCH, 1); step(ST_DECODE, 0); step(ST_RTEXE, 0); step(ST_RTWB, 0);
    // final reset clears the sticky fault
    step(ST_FETCH, 0, 0, 0, 1);
    exp_fault = 1'b0;
    step(ST_RST, 0);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
